// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display geometry and framebuffer addressing.
package chip8_pkg;

  localparam int CHIP8_W = 64;
  localparam int CHIP8_H = 32;
  localparam int FB_BITS = CHIP8_W * CHIP8_H;

  // row*64 + col; the width is a power of two, so this is a concatenation
  function automatic logic [10:0] pix_index(input logic [4:0] row, input logic [5:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/chip8_raster_timing.sv
// Raster h/v counters with registered sync, data-enable and vblank pulse.
module chip8_raster_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          line_end,
  output logic          frame_snap,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          vblank_pulse
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic h_sync_zone;
  logic v_sync_zone;

  assign line_end    = pix_en && (h_cnt == HW'(H_TOTAL - 1));
  // Counters are about to step to (0, V_ACTIVE): first line of vblank
  assign frame_snap  = line_end && (v_cnt == VW'(V_ACTIVE - 1));
  assign h_sync_zone = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign v_sync_zone = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
      de           <= 1'b0;
      vblank_pulse <= 1'b0;
    end else begin
      vblank_pulse <= frame_snap;
      if (pix_en) begin
        de    <= (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        hsync <= h_sync_zone ? SYNC_POL : ~SYNC_POL;
        vsync <= v_sync_zone ? SYNC_POL : ~SYNC_POL;
        if (line_end) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
        end else begin
          h_cnt <= h_cnt + HW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/chip8_scanout.sv
// CHIP-8 framebuffer scanout: per-frame snapshot, integer scaling, letterboxed pixel fetch.
module chip8_scanout
  import chip8_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE    = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic [FB_BITS-1:0] display_in,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               pixel,
  output logic               vblank_pulse
);

  localparam int HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int X_OFF = (H_ACTIVE - CHIP8_W * SCALE) / 2;
  localparam int Y_OFF = (V_ACTIVE - CHIP8_H * SCALE) / 2;

  logic [HW-1:0]      h_cnt, h_rel;
  logic [VW-1:0]      v_cnt, v_rel;
  logic               line_end, frame_snap;
  logic               in_hwin, in_vwin;
  logic [SW-1:0]      sx, sy;
  logic [5:0]         fx;
  logic [4:0]         fy;
  logic [FB_BITS-1:0] frame_buf;

  chip8_raster_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .line_end(line_end), .frame_snap(frame_snap),
    .hsync(hsync), .vsync(vsync), .de(de), .vblank_pulse(vblank_pulse)
  );

  // Offset-relative compare: positions before the window wrap to large values
  assign h_rel   = h_cnt - HW'(X_OFF);
  assign v_rel   = v_cnt - VW'(Y_OFF);
  assign in_hwin = h_rel < HW'(CHIP8_W * SCALE);
  assign in_vwin = v_rel < VW'(CHIP8_H * SCALE);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_buf <= '0;
      sx        <= '0;
      fx        <= '0;
      sy        <= '0;
      fy        <= '0;
      pixel     <= 1'b0;
    end else begin
      if (frame_snap)
        frame_buf <= display_in;
      if (pix_en) begin
        pixel <= in_hwin && in_vwin && frame_buf[pix_index(fy, fx)];
        if (in_hwin) begin
          if (sx == SW'(SCALE - 1)) begin
            sx <= '0;
            fx <= fx + 6'd1;
          end else begin
            sx <= sx + SW'(1);
          end
        end else begin
          sx <= '0;
          fx <= '0;
        end
        // Row counters step at end of line, so they are valid for the whole next line
        if (line_end) begin
          if (in_vwin) begin
            if (sy == SW'(SCALE - 1)) begin
              sy <= '0;
              fy <= fy + 5'd1;
            end else begin
              sy <= sy + SW'(1);
            end
          end else begin
            sy <= '0;
            fy <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_chip8_scanout.sv
// Scoreboard bench for chip8_scanout using a compact raster geometry.
module tb_chip8_scanout;

  localparam int SCALE    = 2;
  localparam int H_ACTIVE = 132;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 4;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 68;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_OFF    = (H_ACTIVE - 64 * SCALE) / 2;
  localparam int Y_OFF    = (V_ACTIVE - 32 * SCALE) / 2;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic pixel;
    logic vb;
  } out_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_en;
  logic [2047:0] display_in;
  logic          hsync, vsync, de, pixel, vblank_pulse;
  out_t          obs;

  chip8_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SCALE(SCALE), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .display_in(display_in),
    .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel), .vblank_pulse(vblank_pulse)
  );

  always #5 clk = ~clk;

  assign obs = {hsync, vsync, de, pixel, vblank_pulse};

  out_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            m_h = 0, m_v = 0;
  logic [2047:0] m_fb = '0;
  out_t          m_out = '0;
  out_t          s_out;
  int            run_px;

  // Reference raster: computes the expected registered outputs for this clk
  task automatic model_step();
    out_t e;
    if (reset) begin
      m_h  = 0;
      m_v  = 0;
      m_fb = '0;
      e    = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, pixel: 1'b0, vb: 1'b0};
    end else if (pix_en) begin
      e.hsync = !(m_h >= H_ACTIVE + H_FP && m_h < H_ACTIVE + H_FP + H_SYNC);
      e.vsync = !(m_v >= V_ACTIVE + V_FP && m_v < V_ACTIVE + V_FP + V_SYNC);
      e.de    = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
      if (m_h >= X_OFF && m_h < X_OFF + 64 * SCALE && m_v >= Y_OFF && m_v < Y_OFF + 32 * SCALE)
        e.pixel = m_fb[((m_v - Y_OFF) / SCALE) * 64 + (m_h - X_OFF) / SCALE];
      else
        e.pixel = 1'b0;
      e.vb = (m_h == H_TOTAL - 1) && (m_v == V_ACTIVE - 1);
      if (e.vb) m_fb = display_in;
      m_h++;
      if (m_h == H_TOTAL) begin
        m_h = 0;
        m_v++;
        if (m_v == V_TOTAL) m_v = 0;
      end
    end else begin
      e    = m_out;
      e.vb = 1'b0;
    end
    m_out = e;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    out_t e;
    int   ph, pv;
    ph = m_h;
    pv = m_v;
    model_step();
    @(posedge clk);
    #1;
    e     = exp_q.pop_front();
    s_out = obs;
    checks++;
    assert (s_out === e) else begin
      errors++;
      $error("FAIL raster h=%0d v=%0d observed=%b expected=%b", ph, pv, s_out, e);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic run_to(input int th, input int tv, input string tag);
    int n;
    n      = 0;
    run_px = 0;
    while (!(m_h == th && m_v == tv) && n < H_TOTAL * V_TOTAL + 10) begin
      tick();
      if (s_out.pixel) run_px++;
      n++;
    end
    check_int({tag, "_reached"}, int'(m_h == th && m_v == tv), 1);
  endtask

  initial begin
    int   hs, vs, den, px, vb, hold;
    int   n;
    out_t prev;

    reset      = 1'b1;
    pix_en     = 1'b1;
    display_in = '0;
    repeat (10) tick();

    reset         = 1'b0;
    display_in[0]    = 1'b1;
    display_in[2047] = 1'b1;
    run_to(0, V_ACTIVE, "first_snapshot");
    check_int("frame0_blank_px", run_px, 0);

    // One whole frame; live display cleared mid-image must not tear the snapshot
    hs = 0; vs = 0; den = 0; px = 0; vb = 0;
    for (int i = 0; i < H_TOTAL * V_TOTAL; i++) begin
      if (m_h == 0 && m_v == Y_OFF + 1) display_in = '0;
      tick();
      if (!s_out.hsync) hs++;
      if (!s_out.vsync) vs++;
      if (s_out.de) den++;
      if (s_out.pixel) px++;
      if (s_out.vb) vb++;
    end
    check_int("hsync_low_steps", hs, H_SYNC * V_TOTAL);
    check_int("vsync_low_steps", vs, V_SYNC * H_TOTAL);
    check_int("de_high_steps", den, H_ACTIVE * V_ACTIVE);
    check_int("pixel_high_steps", px, 2 * SCALE * SCALE);
    check_int("vblank_pulses", vb, 1);

    run_to(0, Y_OFF + SCALE + 1, "cleared_frame");
    check_int("cleared_frame_px", run_px, 0);

    // Half-rate pixel enable: widths double in clks, outputs hold on idle clks
    display_in[0] = 1'b1;
    hs = 0; hold = 0; vb = 0;
    prev = s_out;
    for (int i = 0; i < 4 * H_TOTAL; i++) begin
      pix_en = (i % 2 == 0);
      tick();
      if (!s_out.hsync) hs++;
      if (!pix_en && s_out[4:1] !== prev[4:1]) hold++;
      if (s_out.vb) vb++;
      prev = s_out;
    end
    check_int("half_rate_hsync_clks", hs, 4 * H_SYNC);
    check_int("half_rate_hold", hold, 0);
    check_int("half_rate_no_vblank", vb, 0);

    n = 0;
    while (!(m_v == 20 && m_h == 37) && n < 4 * H_TOTAL * V_TOTAL) begin
      pix_en = ~pix_en;
      tick();
      n++;
    end
    check_int("reach_v20", int'(m_v == 20 && m_h == 37), 1);

    // Mid-frame reset with pix_en high: reset wins, raster restarts blank
    reset  = 1'b1;
    pix_en = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_int("restart_de", int'(s_out.de), 1);
    check_int("restart_hsync", int'(s_out.hsync), 1);
    run_to(0, V_ACTIVE, "post_reset_snapshot");
    check_int("post_reset_blank_px", run_px, 0);
    run_to(0, Y_OFF + SCALE, "post_reset_image");
    check_int("post_reset_bit0_px", run_px, SCALE * SCALE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chip8_scanout.md
Name: chip8_scanout

Overview:
- Reader side of the CHIP-8 framebuffer. Takes the 2048-bit display vector (64x32, bit index = row*64 + col) produced by the display writer.
- Serialises it into a VGA-style raster: hsync, vsync, data-enable and a 1-bit pixel, with integer pixel replication and letterboxing.
- Snapshots the framebuffer once per frame at vblank entry, so the output never tears.
- Emits a once-per-frame vblank pulse that drives the 60 Hz delay/sound timers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SCALE, 10, output pixels per CHIP-8 pixel, both axes; 64*SCALE <= H_ACTIVE and 32*SCALE <= V_ACTIVE
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-clock enable; raster advances one pixel per clk with pix_en=1
- display_in  in  2048  live framebuffer from the display writer
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- de  out  1  data enable, high in the visible region
- pixel  out  1  pixel value; 0 outside the CHIP-8 image window
- vblank_pulse  out  1  one clk wide, once per frame at vblank entry

Behaviour:
- Clocking and reset: one clock, synchronous active-high reset. Reset has priority over pix_en.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL likewise (525).
  - X_OFF = (H_ACTIVE-64*SCALE)/2 (0 by default); Y_OFF = (V_ACTIVE-32*SCALE)/2 (80 by default).
- Counters:
  - h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1 advance only on pix_en.
  - h_cnt wraps to 0 and increments v_cnt. v_cnt wraps to 0 after V_TOTAL-1.
- Scaling uses no divider:
  - Sub-counter sx 0..SCALE-1 plus column fx 0..63 run while h_cnt is in [X_OFF, X_OFF+64*SCALE).
  - Sub-counter sy plus row fy 0..31 advance once per line while v_cnt is in [Y_OFF, Y_OFF+32*SCALE).
  - All of these reset to 0 at the start of each window.
- Window: pixel = frame_buf[fy*64+fx] inside the window, else 0.
- Sync and enable:
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync is active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Latency: all outputs are registered. On a pix_en cycle they take the values for the pre-increment (h_cnt, v_cnt), so outputs lag the counters by exactly one pixel step.
- pix_en low: counters and hsync/vsync/de/pixel hold their values.
- Snapshot:
  - On the pix_en cycle where the counters move to (h=0, v=V_ACTIVE), frame_buf <= display_in and vblank_pulse=1 for that single clk.
  - vblank_pulse is 0 on every other clk.
  - display_in changes at any other time have no effect on output until the next snapshot.
- Reset values:
  - h_cnt, v_cnt, all sub-counters and frame_buf = 0.
  - de=0, pixel=0, vblank_pulse=0; hsync=vsync=~SYNC_POL (inactive).
- Reset mid-frame: the raster restarts at (0,0) on the next pix_en after reset deasserts, with a blank frame until the first snapshot.
- Simultaneous events: a snapshot coinciding with a display writer draw captures the pre-draw display_in value. This is accepted; the next frame shows the draw.

Decomposition:
- Shared chip8 package: CHIP8_W=64, CHIP8_H=32, FB_BITS=2048, and the pixel index function row*64+col (also used by chip8_display).
- One natural sub-module, chip8_raster_timing. It holds the h/v counters plus sync/de/vblank generation. chip8_scanout adds snapshot, scaling and pixel fetch.

Test Plan:
- Reset with pix_en=1 held, 10 clks -> hsync=vsync=1, de=0, pixel=0, vblank_pulse=0 throughout.
- pix_en constant 1, one full frame -> hsync low for exactly 96 of every 800 pix_en steps; vsync low for 2 lines (1600 steps); de high for 640x480; vblank_pulse once per 420000 clks.
- display_in bit 0 set, all else 0 -> pixel=1 only for h 0..9 on lines 80..89 (one-step output lag); zero elsewhere, including lines 0..79.
- display_in bit 2047 set -> pixel=1 only for h 630..639 on lines 390..399.
- Snapshot taken with bit 0 set, then display_in cleared mid-frame at v=85 -> lines 86..89 still show the pixel; after the next vblank_pulse the pixel is absent.
- pix_en asserted every other clk -> all widths double in clk count, outputs hold on idle clks, vblank_pulse still 1 clk wide. Reset asserted at v=200 -> next frame starts at (0,0), blank until the first snapshot.
